// File: rtl/half_adder_chk_pkg.sv
// Shared types and constants for the half-adder response checker.
package half_adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CNT_W_DEF = 16;
    localparam logic [CNT_W_DEF-1:0] FAIL_IDX_NONE = '1;
    localparam int unsigned LAT_MAX = 8;

endpackage

// File: rtl/ha_chk_delay_line.sv
// LAT-deep {valid, data} shift register aligning expectations with DUT latency.
module ha_chk_delay_line #(
    parameter int unsigned LAT = 1,
    parameter int unsigned DW  = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [LAT-1:0] valid_q;
    logic [DW-1:0]  data_q [LAT];

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int i = 1; i < int'(LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/half_adder_resp_checker.sv
// Self-checking response end for the half-adder path: predicts, aligns, compares, counts.
// Optional watchdog enabled by defining HALF_ADDER_CHK_TIMEOUT_EN.
module half_adder_resp_checker
    import half_adder_chk_pkg::*;
#(
    parameter int unsigned W       = 1,
    parameter int unsigned LAT     = 1,
    parameter int unsigned NUM_VEC = 4,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             timeout
);

    localparam int unsigned DW      = W + 1;
    localparam int unsigned LAT_EFF = (LAT < 1) ? 1 : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
    localparam logic [CNT_W-1:0] IDX_NONE  = '1;
    localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] iss_cnt;
    logic [CNT_W-1:0] chk_nxt;
    logic [CNT_W-1:0] iss_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic [CNT_W-1:0] idx_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             pass_nxt;
    logic             tmo_nxt;
    logic             enter_run;
    logic             accept;
    logic             check;
    logic             mismatch;
    logic             tmo_hit;
    logic [DW-1:0]    exp_sum;
    logic [DW-1:0]    dl_data;
    logic             dl_valid;

    // Starts are only honoured outside RUN; vectors only while the run still needs them.
    assign enter_run = start && (state != RUN);
    assign accept    = (state == RUN) && vec_valid && (iss_cnt < NUM_VEC_C);
    assign check     = (state == RUN) && dl_valid;
    assign mismatch  = check && ({dut_cout, dut_sum} != dl_data);
    assign exp_sum   = DW'(a) + DW'(b);

    ha_chk_delay_line #(
        .LAT (LAT_EFF),
        .DW  (DW)
    ) u_delay (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (enter_run),
        .in_valid  (accept),
        .in_data   (exp_sum),
        .out_valid (dl_valid),
        .out_data  (dl_data)
    );

`ifdef HALF_ADDER_CHK_TIMEOUT_EN
    localparam int unsigned WDOG_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_nxt;

    // Watchdog restarts on every check and fires after TIMEOUT idle cycles in RUN.
    assign tmo_hit = (state == RUN) && !check && (wdog == WDOG_W'(TIMEOUT));

    always_comb begin
        wdog_nxt = wdog;
        if (enter_run || check) begin
            wdog_nxt = '0;
        end else if ((state == RUN) && !tmo_hit) begin
            wdog_nxt = wdog + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wdog <= '0;
        end else begin
            wdog <= wdog_nxt;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The run finishes in the same edge as the final check so DONE follows it directly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if ((chk_nxt == NUM_VEC_C) || tmo_hit) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
        pass_nxt = done_nxt && (err_nxt == '0) && !tmo_nxt;
    end

    always_comb begin
        chk_nxt = chk_cnt;
        iss_nxt = iss_cnt;
        err_nxt = err_cnt;
        idx_nxt = first_fail_idx;
        tmo_nxt = timeout;
        if (enter_run) begin
            chk_nxt = '0;
            iss_nxt = '0;
            err_nxt = '0;
            idx_nxt = IDX_NONE;
            tmo_nxt = 1'b0;
        end else begin
            if (accept) iss_nxt = iss_cnt + CNT_W'(1);
            if (check)  chk_nxt = chk_cnt + CNT_W'(1);
            // A zero error count marks the first mismatch; saturation never returns it to zero.
            if (mismatch) begin
                if (err_cnt == '0) idx_nxt = chk_cnt;
                if (err_cnt != '1) err_nxt = err_cnt + CNT_W'(1);
            end
            if (tmo_hit) tmo_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            chk_cnt        <= '0;
            iss_cnt        <= '0;
            err_cnt        <= '0;
            first_fail_idx <= IDX_NONE;
            timeout        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            chk_cnt        <= chk_nxt;
            iss_cnt        <= iss_nxt;
            err_cnt        <= err_nxt;
            first_fail_idx <= idx_nxt;
            timeout        <= tmo_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
        end
    end

endmodule

// File: tb/tb_half_adder_resp_checker.sv
// Bench for half_adder_resp_checker: a latency-1 adder model with fault modes feeds the
// checker, and expected counts come from the list of vectors that a run should consume.
module tb_half_adder_resp_checker;
    import half_adder_chk_pkg::*;

    localparam int unsigned W   = 1;
    localparam int unsigned LAT = 1;
    localparam int unsigned NV  = 4;
    localparam int unsigned CW  = 16;

    logic          clk;
    logic          rstn;
    logic          start;
    logic          vec_valid;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  dut_sum;
    logic          dut_cout;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] first_fail_idx;
    logic          timeout;

    int         total;
    int         bad;
    int         fault_mode;
    logic [1:0] pend;
    bit         wrong_q[$];

    half_adder_resp_checker #(
        .W       (W),
        .LAT     (LAT),
        .NUM_VEC (NV),
        .CNT_W   (CW),
        .TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .vec_valid      (vec_valid),
        .a              (a),
        .b              (b),
        .dut_sum        (dut_sum),
        .dut_cout       (dut_cout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_fail_idx (first_fail_idx),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    // Response of the adder under test, optionally faulty.
    function automatic logic [1:0] resp(input logic av, input logic bv);
        logic [1:0] s;
        s = 2'(av) + 2'(bv);
        if (fault_mode == 1) begin
            s[1] = 1'b0;
        end else if (fault_mode == 2 && $urandom_range(9, 0) < 3) begin
            s = s ^ 2'($urandom_range(3, 1));
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: registers observed are those of the new cycle; inputs for it are driven here.
    task automatic cyc(input logic st, input logic vv, input logic av, input logic bv, input bit cnt);
        logic [1:0] r;
        @(posedge clk);
        #1;
        {dut_cout, dut_sum} = pend;
        r = resp(av, bv);
        pend = r;
        if (cnt) wrong_q.push_back(r != (2'(av) + 2'(bv)));
        start     = st;
        vec_valid = vv;
        a         = av;
        b         = bv;
    endtask

    task automatic check_result(input string tag);
        int e;
        int idx;
        e   = 0;
        idx = -1;
        foreach (wrong_q[i]) begin
            if (wrong_q[i]) begin
                if (idx < 0) idx = i;
                e++;
            end
        end
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(e));
        chk({tag, ".first_fail_idx"}, 32'(first_fail_idx),
            (idx < 0) ? 32'(FAIL_IDX_NONE) : 32'(idx));
        chk({tag, ".pass"}, 32'(pass), 32'(e == 0));
        chk({tag, ".timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic run(input string tag, input int mode, input int gmin, input int gmax,
                       input bit seq, input bit extras, input bit start_late);
        logic av;
        logic bv;
        fault_mode = mode;
        wrong_q.delete();
        cyc(1'b1, extras, rb(), rb(), 1'b0);
        for (int i = 0; i < int'(NV); i++) begin
            int g;
            g = int'($urandom_range(gmax, gmin));
            for (int k = 0; k < g; k++) begin
                cyc(extras ? rb() : 1'b0, 1'b0, rb(), rb(), 1'b0);
                chk({tag, ".gap_busy"}, 32'(busy), 32'd1);
            end
            av = seq ? i[1] : rb();
            bv = seq ? i[0] : rb();
            cyc(1'b0, 1'b1, av, bv, 1'b1);
        end
        cyc(start_late, extras, rb(), rb(), 1'b0);
        chk({tag, ".done_at_last_check"}, 32'(done), 32'd0);
        chk({tag, ".busy_at_last_check"}, 32'(busy), 32'd1);
        cyc(1'b0, extras, rb(), rb(), 1'b0);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_after"}, 32'(busy), 32'd0);
        check_result(tag);
        cyc(1'b0, extras, rb(), rb(), 1'b0);
        chk({tag, ".done_held"}, 32'(done), 32'd1);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        fault_mode = 0;
        pend       = '0;
        wrong_q.delete();
        rstn       = 1'b0;
        start      = 1'b0;
        vec_valid  = 1'b0;
        a          = '0;
        b          = '0;
        dut_sum    = '0;
        dut_cout   = 1'b0;

        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.pass", 32'(pass), 32'd0);
        chk("rst.err_cnt", 32'(err_cnt), 32'd0);
        chk("rst.first_fail_idx", 32'(first_fail_idx), 32'(FAIL_IDX_NONE));
        chk("rst.timeout", 32'(timeout), 32'd0);
        rstn = 1'b1;

        // Vectors while idle must not start or disturb anything.
        repeat (3) cyc(1'b0, 1'b1, rb(), rb(), 1'b0);
        chk("idle.busy", 32'(busy), 32'd0);
        chk("idle.done", 32'(done), 32'd0);
        chk("idle.err_cnt", 32'(err_cnt), 32'd0);

        run("seq", 0, 0, 0, 1'b1, 1'b0, 1'b0);
        run("stuck_cout", 1, 0, 0, 1'b1, 1'b0, 1'b0);
        run("spaced", 0, 9, 9, 1'b1, 1'b0, 1'b0);
        run("extras", 0, 0, 0, 1'b1, 1'b1, 1'b1);

        repeat (3) cyc(1'b0, 1'b1, rb(), rb(), 1'b0);
        chk("done_vec.done", 32'(done), 32'd1);
        chk("done_vec.err_cnt", 32'(err_cnt), 32'd0);
        chk("done_vec.pass", 32'(pass), 32'd1);

        // Reset after two checks with a faulty vector still in flight.
        fault_mode = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        fault_mode = 1;
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst.busy_before", 32'(busy), 32'd1);
        rstn = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.pass", 32'(pass), 32'd0);
        chk("midrst.err_cnt", 32'(err_cnt), 32'd0);
        chk("midrst.first_fail_idx", 32'(first_fail_idx), 32'(FAIL_IDX_NONE));
        chk("midrst.timeout", 32'(timeout), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst.err_after", 32'(err_cnt), 32'd0);
        run("restart", 0, 0, 1, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            run("random", 2, 0, 3, 1'b0, r[0], r[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/half_adder_resp_checker.md
Name: half_adder_resp_checker

Overview:
- Synthesizable self-checking response end for the half-adder path; the counterpart of the exhaustive stimulus generator.
- Takes each applied operand vector {a,b} plus a valid strobe and computes the expected {cout,sum} internally.
- Delays the expectation to align with DUT response latency, compares, counts errors, and reports pass/fail once NUM_VEC responses have been checked.
- Sits beside the adder under test in BIST-style wrappers and FPGA smoke tests.

Parameters:
- W, 1, operand width; sum is W bits, cout is 1 bit.
- LAT, 1, DUT latency in cycles from vec_valid to its response; legal range 1..8.
- NUM_VEC, 4, number of responses checked per run; 1..2^16-1.
- CNT_W, 16, width of the error and index counters.
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse that begins a run.
- vec_valid  in  1  operand vector applied to the DUT this cycle.
- a  in  W  operand a as applied to the DUT.
- b  in  W  operand b as applied to the DUT.
- dut_sum  in  W  DUT sum output.
- dut_cout  in  1  DUT carry output.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE, held until the next start.
- pass  out  1  done && err_cnt==0 && !timeout.
- err_cnt  out  CNT_W  number of mismatches, saturating.
- first_fail_idx  out  CNT_W  index of the first mismatching response; all-ones if none.
- timeout  out  1  watchdog expired (tied 0 without the feature).

Behaviour:
- Clock and reset: one clock, clk; reset rstn is synchronous and active-low.
- Reset values: state IDLE, busy=0, done=0, pass=0, err_cnt=0, first_fail_idx=all-ones, timeout=0, delay line cleared.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: chk_cnt==NUM_VEC -> DONE.
  - DONE: start -> RUN.
- Entering RUN clears err_cnt, first_fail_idx, chk_cnt, iss_cnt and timeout, and flushes the delay line.
- Issue side: vec_valid is accepted only in RUN and only while iss_cnt<NUM_VEC. Accepted vectors increment iss_cnt and push exp={a+b} (W+1 bits, unsigned, no truncation) into the delay line. All other vec_valid pulses are ignored.
- Delay line: LAT stages of {valid,exp}. A response is checked in the cycle its valid bit leaves stage LAT-1, i.e. exactly LAT cycles after acceptance.
- Check: compare {dut_cout,dut_sum} with exp.
  - On mismatch: err_cnt increments, saturating at all-ones.
  - If this is the first mismatch, first_fail_idx = chk_cnt.
  - chk_cnt increments on every check.
- DONE is entered on the cycle after the NUM_VEC-th check. done and pass are registered and valid from that cycle.
- Boundary cases:
  - start while in RUN is ignored.
  - start in the same cycle as the final check: the check completes, the block enters DONE, and the start is ignored.
  - vec_valid in the same cycle as start is ignored; the first vector is accepted the cycle after start.
  - Back-to-back vec_valid every cycle is supported at full throughput.
  - Reset asserted mid-run returns the block to IDLE with all reset values; in-flight expectations are discarded.
  - dut_* inputs are don't-care when no delayed valid is present.

Optional Feature:
- Macro: HALF_ADDER_CHK_TIMEOUT_EN.
- Defined: in RUN, a wdog counter resets on every check and increments otherwise. When wdog==TIMEOUT, timeout=1 and the block goes to DONE, so pass=0.
- Undefined: no watchdog logic; timeout is constant 0; RUN waits indefinitely.

Decomposition:
- Package half_adder_chk_pkg:
  - state enum (IDLE, RUN, DONE);
  - CNT_W default;
  - FAIL_IDX_NONE constant (all-ones);
  - LAT_MAX=8.
- Sub-module ha_chk_delay_line: parameterized LAT-deep {valid, W+1-bit data} shift register with synchronous clear.

Test Plan (W=1, LAT=1, NUM_VEC=4 unless stated):
- Correct DUT, start, then {a,b}=0,1,2,3 on consecutive cycles -> checks at cycles 2..5; done=1 at cycle 6; pass=1, err_cnt=0, first_fail_idx=16'hFFFF.
- DUT with cout stuck-at-0 -> only vector 3 mismatches; err_cnt=1, first_fail_idx=3, pass=0.
- Vectors spaced every 10 cycles, as the stimulus generator applies them -> same result as the first case; busy stays high through the gaps.
- Extra 5th vec_valid, plus vec_valid while in IDLE -> ignored; err_cnt unaffected; done after exactly 4 checks.
- rstn low for 1 cycle after 2 checks, then restart -> outputs return to reset values; the new run passes cleanly.
- With HALF_ADDER_CHK_TIMEOUT_EN, TIMEOUT=64, only 3 vectors sent -> 64 cycles after the third check: timeout=1, done=1, pass=0.
